// File: rtl/t08_combinational_logic.sv
// t08_combinational_logic
//   Purpose: combinational AND-OR/XOR function z, with z registered,
//            a registered rising-edge pulse, and a saturating count of
//            the cycles where the registered z is high.
//   Parameters:
//     CNT_W   width of the z-high cycle counter (>= 2)
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous active-high reset
//     a..e    logic operands
//     z       (a & b) | ((c ^ d) & ~e), combinational
//     z_q     z registered (1-cycle latency)
//     z_rise  registered pulse on a 0->1 transition of z_q
//     z_cnt   saturating count of cycles with z_q = 1
module t08_combinational_logic #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    output logic             z,
    output logic             z_q,
    output logic             z_rise,
    output logic [CNT_W-1:0] z_cnt
);

    logic             z_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        z_d = (a & b) | ((c ^ d) & ~e);
    end

    // Next-state for the pulse and counter; the counter advances on the
    // registered z, so it lags z_q by one edge and stops at all-ones.
    always_comb begin
        rise_d = z_d & ~z_q;
        cnt_d  = cnt_q;
        if (z_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q    <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            z_q    <= z_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z      = z_d;
    assign z_rise = rise_q;
    assign z_cnt  = cnt_q;

endmodule

// File: tb/tb_t08_combinational_logic.sv
module tb_t08_combinational_logic;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
    logic       z, z_q, z_rise;
    logic [7:0] z_cnt;
    logic       z2, z_q2, z_rise2;
    logic [1:0] z_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int m_zq = 0, m_rise = 0, m_cnt = 0, m_cnt2 = 0;
    int rise_seen;

    always #5 clk = ~clk;

    t08_combinational_logic dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e),
        .z(z), .z_q(z_q), .z_rise(z_rise), .z_cnt(z_cnt)
    );

    t08_combinational_logic #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e),
        .z(z2), .z_q(z_q2), .z_rise(z_rise2), .z_cnt(z_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // z is 1 when a and b are both 1, or when c differs from d and e is 0
    function automatic int ref_z(input logic [4:0] v);
        if (v[4] && v[3]) return 1;
        if ((v[2] != v[1]) && !v[0]) return 1;
        return 0;
    endfunction

    function automatic int sat(input int x, input int top);
        return (x > top) ? top : x;
    endfunction

    task automatic drive(input logic [4:0] v);
        {a, b, c, d, e} = v;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".z_q"},     32'(z_q),     32'(m_zq));
        check({tag, ".z_rise"},  32'(z_rise),  32'(m_rise));
        check({tag, ".z_cnt"},   32'(z_cnt),   32'(m_cnt));
        check({tag, ".z_q2"},    32'(z_q2),    32'(m_zq));
        check({tag, ".z_rise2"}, 32'(z_rise2), 32'(m_rise));
        check({tag, ".z_cnt2"},  32'(z_cnt2),  32'(m_cnt2));
    endtask

    // Call just after a negedge: apply v, check z, clock once, check registers.
    task automatic cycle(input string tag, input logic [4:0] v);
        int zv;
        zv = ref_z(v);
        drive(v);
        #1;
        check({tag, ".z"},  32'(z),  32'(zv));
        check({tag, ".z2"}, 32'(z2), 32'(zv));
        @(posedge clk);
        if (!rst) begin
            m_rise = (zv == 1 && m_zq == 0) ? 1 : 0;
            if (m_zq == 1) begin
                m_cnt  = sat(m_cnt + 1, 255);
                m_cnt2 = sat(m_cnt2 + 1, 3);
            end
            m_zq = zv;
        end
        @(negedge clk);
        check_regs(tag);
        if (z_rise) rise_seen++;
    endtask

    task automatic model_reset();
        m_zq = 0; m_rise = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    logic [4:0] spot_v [8] = '{5'b00000, 5'b00100, 5'b00101, 5'b00110,
                               5'b11000, 5'b11111, 5'b10100, 5'b01011};
    int         spot_z [8] = '{0, 1, 0, 0, 1, 1, 1, 0};
    int         lat_z  [6] = '{0, 0, 1, 1, 0, 1};
    int         sat_c  [6] = '{0, 1, 2, 3, 3, 3};

    initial begin
        #1;
        check_regs("reset");

        // exhaustive sweep during reset: z follows inputs, registers stay 0
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            drive(v);
            #10;
            check("sweep.z", 32'(z), 32'(ref_z(v)));
        end
        check_regs("sweep_hold");

        for (int i = 0; i < 8; i++) begin
            drive(spot_v[i]);
            #1;
            check("spot.z", 32'(z), 32'(spot_z[i]));
        end

        // e gates the c^d term with no clock involvement
        for (int i = 0; i < 4; i++) begin
            drive({4'b0010, 1'(i % 2)});
            #1;
            check("etoggle.z", 32'(z), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // release and latency/pulse sequence
        @(negedge clk);
        rst = 1'b0;
        rise_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("latency", (lat_z[i] == 1) ? 5'b11000 : 5'b00000);
            check("latency.zq_const", 32'(z_q), 32'(lat_z[i]));
        end
        cycle("latency_tail", 5'b00000);
        check("latency.rise_count", 32'(rise_seen), 32'd2);

        // run z high until the wide counter reaches 5, bounded
        for (int i = 0; i < 20 && m_cnt != 5; i++) cycle("count", 5'b11000);
        check("count.reached5", 32'(z_cnt), 32'd5);

        // async reset mid low phase, away from any edge
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("async_rst");
        check("async_rst.z", 32'(z), 32'd1);
        drive(5'b00110);
        #1;
        check("async_rst.z_follow", 32'(z), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_regs("rst_hold");

        // release with a=b=1
        rst = 1'b0;
        cycle("release1", 5'b11000);
        check("release1.rise", 32'(z_rise), 32'd1);
        check("release1.zq",   32'(z_q),    32'd1);
        cycle("release2", 5'b11000);
        check("release2.rise", 32'(z_rise), 32'd0);
        check("release2.cnt",  32'(z_cnt),  32'd1);

        // saturation of the 2-bit counter
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle("sat", 5'b11000);
            check("sat.cnt2_const", 32'(z_cnt2), 32'(sat_c[i]));
        end

        // randomized stimulus against the model, with occasional long z-high runs
        for (int i = 0; i < 400; i++) begin
            logic [4:0] v;
            v = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) v = 5'b11001;
            cycle("random", v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t08_combinational_logic.md
T08_COMBINATIONAL_LOGIC -- requirements
Module: t08_combinational_logic

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, which sets the width of the z-high cycle counter (minimum 2).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have ports a, b, c, d and e, each an input of 1 bit: logic operands.
REQ-005 The module SHALL have port z, output, 1 bit: combinational logic result.
REQ-006 The module SHALL have port z_q, output, 1 bit: z registered.
REQ-007 The module SHALL have port z_rise, output, 1 bit: registered pulse marking a 0->1 transition of z_q.
REQ-008 The module SHALL have port z_cnt, output, CNT_W bits: saturating count of cycles with z_q = 1.

Function
REQ-009 z SHALL equal (a AND b) OR ((c XOR d) AND NOT e), purely combinationally, with zero-cycle latency and no dependence on clk or rst.
REQ-010 z SHALL be 1 for exactly these input cases:
  - a=b=1, for any c, d, e;
  - c!=d and e=0, for any a, b.
  z SHALL be 0 in all other cases.
REQ-011 z_q SHALL capture z on every rising clk edge, giving 1-cycle latency.
REQ-012 z_rise SHALL be 1 for exactly one cycle, in the cycle after z_q goes from 0 to 1; it is registered as (z AND NOT z_q).
REQ-013 z_cnt SHALL increment by 1 on each rising edge where z_q = 1.
REQ-014 z_cnt SHALL saturate at all-ones (2^CNT_W - 1) and SHALL NOT wrap.
REQ-015 z_cnt SHALL hold its value when z_q = 0.
REQ-016 If an input changes in the same cycle as a clock edge, the registers SHALL take the z value settled before that edge.
REQ-017 Unknown (X) inputs are outside scope; the design SHALL NOT add X-masking logic.

Reset
REQ-018 Asserting rst SHALL immediately force z_q=0, z_rise=0 and z_cnt=0, without waiting for a clock edge.
REQ-019 These register values SHALL hold for as long as rst is high.
REQ-020 z SHALL continue to follow the inputs during reset.
REQ-021 On the first rising edge after rst deasserts, the registers SHALL resume normal operation. z_rise SHALL assert on that edge if z = 1, because z_q was 0 during reset.
REQ-022 Reset asserted mid-count SHALL clear z_cnt to 0. The count SHALL restart from 0 after release.

Verification
REQ-023 The bench SHALL run an exhaustive sweep of all 32 values of {a,b,c,d,e}, holding each for 10 time units, and check z against REQ-009. Spot checks:
  - 00000 -> z=0
  - 00100 -> z=1
  - 00101 -> z=0
  - 00110 -> z=0
  - 11000 -> z=1
  - 11111 -> z=1
  - 10100 -> z=1
  - 01011 -> z=0
REQ-024 The bench SHALL cover e=1 explicitly: with c^d=1 and a&b=0, toggling e between 0 and 1 SHALL toggle z between 1 and 0 with no clock involvement.
REQ-025 Latency and pulse check: with rst=0 and z driven 0,0,1,1,0,1 over successive cycles, z_q SHALL match one cycle later, and z_rise SHALL pulse exactly twice, one cycle each.
REQ-026 Saturation check: with CNT_W=2 and z held at 1 for 6 cycles, z_cnt SHALL read 0,1,2,3,3,3, lagging z_q by one edge, and SHALL NOT wrap to 0.
REQ-027 Asynchronous reset check: asserting rst between clock edges while z_cnt=5 SHALL zero z_q, z_rise and z_cnt before the next edge. z SHALL still reflect the inputs during reset.
REQ-028 Reset release check: deasserting rst with a=b=1 SHALL produce z_q=1 and z_rise=1 after the first edge, then z_rise=0 and z_cnt=1 after the second edge.
